// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction cache and its memory bus.
// Latency: none (declarations only).
// Backpressure: n/a.
package icache_pkg;

    localparam int XLEN            = 32;
    localparam int ICACHE_LINES    = 32;
    localparam int ICACHE_IDX_BITS = $clog2(ICACHE_LINES);

    // Command encoding on the instruction memory bus.
    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    // Miss-handling controller states.
    typedef enum logic [1:0] {
        IDLE = 2'h0,
        REQ  = 2'h1,
        WAIT = 2'h2
    } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signal bundle of the instruction cache.
// Latency: none (wiring only).
// Backpressure: memory acceptance signalled by a nonzero response tag.
interface icache_if;
    import icache_pkg::*;

    logic [XLEN-1:0] proc2Icache_addr;
    logic [63:0]     Icache2proc_data;
    logic            Icache2proc_valid;
    BUS_COMMAND      proc2Imem_command;
    logic [XLEN-1:0] proc2Imem_addr;
    logic [3:0]      Imem2proc_response;
    logic [63:0]     Imem2proc_data;
    logic [3:0]      Imem2proc_tag;

    // Cache side.
    modport slave (
        input  proc2Icache_addr,
        output Icache2proc_data,
        output Icache2proc_valid,
        output proc2Imem_command,
        output proc2Imem_addr,
        input  Imem2proc_response,
        input  Imem2proc_data,
        input  Imem2proc_tag
    );

    // Fetch stage plus instruction memory side.
    modport master (
        output proc2Icache_addr,
        input  Icache2proc_data,
        input  Icache2proc_valid,
        input  proc2Imem_command,
        input  proc2Imem_addr,
        output Imem2proc_response,
        output Imem2proc_data,
        output Imem2proc_tag
    );

endinterface

// File: rtl/icache_mem.sv
// Direct-mapped tag/valid/data storage: one combinational read port, one write port.
// Latency: read 0 cycles, write visible the cycle after the write edge.
// Backpressure: none; a write is accepted every cycle it is enabled.
module icache_mem #(
    parameter int NUM_LINES = 32,
    parameter int IDX_BITS  = 5,
    parameter int TAG_BITS  = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic                rd_valid,
    output logic [TAG_BITS-1:0] rd_tag,
    output logic [63:0]         rd_data,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0] wr_tag,
    input  logic [63:0]         wr_data
);

    logic [NUM_LINES-1:0] valid;
    logic [TAG_BITS-1:0]  tags [NUM_LINES];
    logic [63:0]          data [NUM_LINES];

    // Valid bits: cleared by reset, set by a fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data arrays are not reset; valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with a single outstanding miss to memory.
// Latency: hit 0 cycles; miss = 1 cycle to request + memory latency + 1 cycle.
// Backpressure: request retried every cycle while memory answers response 0.
module icache
    import icache_pkg::*;
#(
    parameter int NUM_LINES   = ICACHE_LINES,
    parameter int BLOCK_BYTES = 8
) (
    input  logic      clock,
    input  logic      reset,
    icache_if.slave   bus
);

    localparam int OFF_BITS = $clog2(BLOCK_BYTES);
    localparam int IDX_BITS = $clog2(NUM_LINES);
    localparam int TAG_BITS = XLEN - IDX_BITS - OFF_BITS;

    icache_state_t   state, state_next;
    logic [XLEN-1:0] miss_addr, miss_addr_next;
    logic [3:0]      pend_tag, pend_tag_next;
    BUS_COMMAND      cmd;
    logic [XLEN-1:0] mem_addr;
    logic            fill;

    logic [IDX_BITS-1:0] addr_idx;
    logic [TAG_BITS-1:0] addr_tag;
    logic [XLEN-1:0]     addr_blk;
    logic                rd_valid;
    logic [TAG_BITS-1:0] rd_tag;
    logic [63:0]         rd_data;
    logic                hit;
    logic                unused_off;

    assign addr_idx   = bus.proc2Icache_addr[IDX_BITS+OFF_BITS-1:OFF_BITS];
    assign addr_tag   = bus.proc2Icache_addr[XLEN-1:IDX_BITS+OFF_BITS];
    assign addr_blk   = {bus.proc2Icache_addr[XLEN-1:OFF_BITS], {OFF_BITS{1'b0}}};
    assign unused_off = ^bus.proc2Icache_addr[OFF_BITS-1:0];

    icache_mem #(
        .NUM_LINES (NUM_LINES),
        .IDX_BITS  (IDX_BITS),
        .TAG_BITS  (TAG_BITS)
    ) u_mem (
        .clk      (clock),
        .reset    (reset),
        .rd_idx   (addr_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill && !reset),
        .wr_idx   (miss_addr[IDX_BITS+OFF_BITS-1:OFF_BITS]),
        .wr_tag   (miss_addr[XLEN-1:IDX_BITS+OFF_BITS]),
        .wr_data  (bus.Imem2proc_data)
    );

    assign hit = rd_valid && (rd_tag == addr_tag);

    // Outputs are forced quiet while reset is held, whatever the state registers hold.
    assign bus.Icache2proc_valid = !reset && hit;
    assign bus.Icache2proc_data  = (!reset && hit) ? rd_data : 64'h0;
    assign bus.proc2Imem_command = reset ? BUS_NONE : cmd;
    assign bus.proc2Imem_addr    = reset ? '0 : mem_addr;

    // Miss controller: next state, latched addresses and bus request.
    always_comb begin
        state_next     = state;
        miss_addr_next = miss_addr;
        pend_tag_next  = pend_tag;
        cmd            = BUS_NONE;
        mem_addr       = '0;
        fill           = 1'b0;
        case (state)
            IDLE: begin
                if (!hit) begin
                    miss_addr_next = addr_blk;
                    state_next     = REQ;
                end
            end
            REQ: begin
                cmd      = BUS_LOAD;
                mem_addr = miss_addr;
                if (bus.Imem2proc_response != 4'h0) begin
                    pend_tag_next = bus.Imem2proc_response;
                    state_next    = WAIT;
                end else if (addr_blk != miss_addr) begin
                    // Fetch moved elsewhere before memory accepted: drop it.
                    state_next = IDLE;
                end
            end
            WAIT: begin
                // Accepted fills always land, even if fetch has redirected.
                if (pend_tag != 4'h0 && bus.Imem2proc_tag == pend_tag) begin
                    fill          = 1'b1;
                    pend_tag_next = 4'h0;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Controller registers; reset forgets any outstanding transaction.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            miss_addr <= '0;
            pend_tag  <= 4'h0;
        end else begin
            state     <= state_next;
            miss_addr <= miss_addr_next;
            pend_tag  <= pend_tag_next;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache with a transaction-level reference model.
// Latency: n/a.
// Backpressure: memory acceptance driven from the stimulus vectors.
module tb_icache;
    import icache_pkg::*;

    logic clk = 1'b0;
    logic reset;
    icache_if bus();

    icache #(
        .NUM_LINES   (32),
        .BLOCK_BYTES (8)
    ) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [63:0] D1 = 64'hDEADBEEF_00100013;
    localparam logic [63:0] D2 = 64'h11112222_33334444;
    localparam logic [63:0] D3 = 64'hAAAABBBB_CCCCDDDD;
    localparam logic [63:0] DX = 64'hBAD0BAD0_BAD0BAD0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: cache contents as plain arrays, plus the bus transaction in flight.
    bit          m_valid [32];
    int unsigned m_tag   [32];
    logic [63:0] m_data  [32];
    bit          m_req;        // a load is being offered to memory
    logic [31:0] m_req_addr;
    bit          m_out;        // a load was accepted and its data is awaited
    logic [3:0]  m_out_tag;

    // Compare DUT against the model on every falling edge, then advance the model.
    initial begin
        logic [31:0] a;
        int          idx;
        int unsigned tg;
        logic [31:0] blk;
        bit          hit;
        bit          e_valid;
        logic [63:0] e_data;
        BUS_COMMAND  e_cmd;
        logic [31:0] e_addr;
        forever begin
            @(negedge clk);
            a   = bus.proc2Icache_addr;
            idx = int'((a / 8) % 32);
            tg  = a / 256;
            blk = a - (a % 8);
            hit = m_valid[idx] && (m_tag[idx] == tg);
            if (reset) begin
                e_valid = 1'b0;
                e_data  = 64'h0;
                e_cmd   = BUS_NONE;
                e_addr  = 32'h0;
            end else begin
                e_valid = hit;
                e_data  = hit ? m_data[idx] : 64'h0;
                e_cmd   = m_req ? BUS_LOAD : BUS_NONE;
                e_addr  = m_req ? m_req_addr : 32'h0;
            end
            check("model_valid", {63'h0, bus.Icache2proc_valid}, {63'h0, e_valid});
            check("model_data", bus.Icache2proc_data, e_data);
            check("model_cmd", {62'h0, bus.proc2Imem_command}, {62'h0, e_cmd});
            check("model_addr", {32'h0, bus.proc2Imem_addr}, {32'h0, e_addr});
            if (reset) begin
                for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
                m_req = 1'b0;
                m_out = 1'b0;
            end else if (m_req) begin
                if (bus.Imem2proc_response != 4'h0) begin
                    m_req     = 1'b0;
                    m_out     = 1'b1;
                    m_out_tag = bus.Imem2proc_response;
                end else if (blk != m_req_addr) begin
                    m_req = 1'b0;
                end
            end else if (m_out) begin
                if (bus.Imem2proc_tag == m_out_tag) begin
                    m_valid[(m_req_addr / 8) % 32] = 1'b1;
                    m_tag[(m_req_addr / 8) % 32]   = m_req_addr / 256;
                    m_data[(m_req_addr / 8) % 32]  = bus.Imem2proc_data;
                    m_out = 1'b0;
                end
            end else if (!hit) begin
                m_req      = 1'b1;
                m_req_addr = blk;
            end
        end
    end

    task automatic put(input bit r, input logic [31:0] a, input logic [3:0] rsp,
                       input logic [3:0] tg, input logic [63:0] d);
        reset                  = r;
        bus.proc2Icache_addr   = a;
        bus.Imem2proc_response = rsp;
        bus.Imem2proc_tag      = tg;
        bus.Imem2proc_data     = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect4(input string name, input bit v, input logic [63:0] d,
                           input BUS_COMMAND c, input logic [31:0] ad);
        check({name, "_valid"}, {63'h0, bus.Icache2proc_valid}, {63'h0, v});
        check({name, "_data"}, bus.Icache2proc_data, d);
        check({name, "_cmd"}, {62'h0, bus.proc2Imem_command}, {62'h0, c});
        check({name, "_addr"}, {32'h0, bus.proc2Imem_addr}, {32'h0, ad});
    endtask

    // Directed vectors with hand-computed expectations.
    initial begin
        m_req = 1'b0;
        m_out = 1'b0;
        m_req_addr = 32'h0;
        m_out_tag = 4'h0;
        put(1, 32'h100, 0, 0, 0);
        tick();
        expect4("reset", 0, 64'h0, BUS_NONE, 32'h0);
        tick();

        // Cold miss, accept with tag 3, data three cycles later.
        put(0, 32'h100, 0, 0, 0);
        expect4("cold_miss", 0, 64'h0, BUS_NONE, 32'h0);
        tick();
        expect4("req_issue", 0, 64'h0, BUS_LOAD, 32'h100);
        put(0, 32'h100, 3, 0, 0);
        tick();
        put(0, 32'h100, 0, 0, 0);
        expect4("wait_quiet", 0, 64'h0, BUS_NONE, 32'h0);
        tick();
        tick();
        put(0, 32'h100, 0, 3, D1);
        expect4("fill_no_bypass", 0, 64'h0, BUS_NONE, 32'h0);
        tick();
        put(0, 32'h100, 0, 0, 0);
        expect4("hit_100", 1, D1, BUS_NONE, 32'h0);
        put(0, 32'h104, 0, 0, 0);
        expect4("hit_104", 1, D1, BUS_NONE, 32'h0);
        tick();

        // Memory rejects four times, then accepts with tag 5.
        put(1, 32'h100, 0, 0, 0);
        tick();
        tick();
        put(0, 32'h100, 0, 0, 0);
        expect4("miss_after_reset", 0, 64'h0, BUS_NONE, 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            expect4("req_retry", 0, 64'h0, BUS_LOAD, 32'h100);
            tick();
        end
        put(0, 32'h100, 5, 0, 0);
        expect4("req_accept", 0, 64'h0, BUS_LOAD, 32'h100);
        tick();

        // Redirect to 0x200 while waiting: fill for 0x100 still lands.
        put(0, 32'h200, 0, 0, 0);
        expect4("wait_redirect", 0, 64'h0, BUS_NONE, 32'h0);
        tick();
        expect4("wait_redirect2", 0, 64'h0, BUS_NONE, 32'h0);
        tick();
        put(0, 32'h200, 0, 5, D2);
        tick();
        put(0, 32'h200, 0, 0, 0);
        expect4("miss_200", 0, 64'h0, BUS_NONE, 32'h0);
        tick();
        expect4("req_200", 0, 64'h0, BUS_LOAD, 32'h200);
        put(0, 32'h100, 0, 0, 0);
        expect4("back_to_100", 1, D2, BUS_LOAD, 32'h200);
        tick();
        expect4("abandoned", 1, D2, BUS_NONE, 32'h0);
        tick();
        expect4("no_new_req", 1, D2, BUS_NONE, 32'h0);
        tick();

        // Conflict: 0x200 evicts 0x100 from line 0.
        put(0, 32'h200, 0, 0, 0);
        tick();
        put(0, 32'h200, 6, 0, 0);
        expect4("req_200b", 0, 64'h0, BUS_LOAD, 32'h200);
        tick();
        put(0, 32'h200, 0, 6, D3);
        tick();
        put(0, 32'h200, 0, 0, 0);
        expect4("hit_200", 1, D3, BUS_NONE, 32'h0);
        put(0, 32'h100, 0, 0, 0);
        expect4("evicted_100", 0, 64'h0, BUS_NONE, 32'h0);
        tick();
        expect4("rereq_100", 0, 64'h0, BUS_LOAD, 32'h100);
        put(0, 32'h100, 2, 0, 0);
        tick();

        // Reset while waiting on tag 2; a late tag 2 must be ignored.
        put(0, 32'h100, 0, 0, 0);
        expect4("wait_tag2", 0, 64'h0, BUS_NONE, 32'h0);
        tick();
        put(1, 32'h100, 0, 0, 0);
        expect4("reset_in_wait", 0, 64'h0, BUS_NONE, 32'h0);
        tick();
        put(0, 32'h100, 0, 2, DX);
        expect4("stale_tag", 0, 64'h0, BUS_NONE, 32'h0);
        tick();
        expect4("still_miss", 0, 64'h0, BUS_LOAD, 32'h100);
        tick();
        put(0, 32'h100, 0, 0, 0);
        expect4("still_req", 0, 64'h0, BUS_LOAD, 32'h100);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
